uart_tx_arbiter: RTL

Shares the UART transmit FIFO write port between NREQ byte-stream requesters, e.g. CPU console, debug monitor and DMA log.
- Round-robin arbitration; the grant is locked for a whole packet, from grant to the byte flagged last.
- A stall watchdog frees the port when a granted requester stops mid-packet.
- Sits between the requesters and the FIFO write side (wr_en/din/full) in the Clk domain.

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between NREQ byte streams.
// Grants are held for a whole packet; a watchdog frees the port if the owner stalls.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 11
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                enable,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic                fifo_wr,
   output logic [7:0]          fifo_wdata,
   input  logic                fifo_full,
   output logic [NREQ-1:0]     grant,
   output logic                busy,
   output logic                timeout_err,
   output logic [2:0]          timeout_id
);

   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [2:0]        last_id, last_id_nxt;
   logic [NREQ-1:0]   grant_nxt;
   logic [CW-1:0]     tcnt, tcnt_nxt;
   logic              terr_nxt;
   logic [2:0]        tid_nxt;
   logic              found;
   logic [2:0]        winner;
   logic              g_valid, g_last;
   logic [7:0]        g_data;
   logic              xfer_fire;

   // Round-robin search: indices above last_id first, then wrap to the low end
   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (i > int'(last_id)) && req_valid[i]) begin
            found  = 1'b1;
            winner = 3'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found  = 1'b1;
            winner = 3'(i);
         end
      end
   end

   always_comb begin
      g_valid = |(req_valid & grant);
      g_last  = |(req_last & grant);
      g_data  = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) g_data = g_data | req_data[8*i +: 8];
      end
   end

   assign busy       = (state == XFER);
   assign xfer_fire  = busy & g_valid & ~fifo_full;
   assign fifo_wr    = xfer_fire;
   assign fifo_wdata = xfer_fire ? g_data : 8'h00;
   assign req_ready  = (busy && !fifo_full) ? grant : '0;

   // Backpressure clears the watchdog since a full FIFO is not the owner's stall
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      last_id_nxt = last_id;
      tcnt_nxt    = tcnt;
      terr_nxt    = 1'b0;
      tid_nxt     = timeout_id;
      case (state)
         IDLE: begin
            if (enable && found) begin
               state_nxt   = XFER;
               grant_nxt   = NREQ'(1) << winner;
               last_id_nxt = winner;
               tcnt_nxt    = '0;
            end
         end
         XFER: begin
            if (xfer_fire) begin
               tcnt_nxt = '0;
               if (g_last) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end else if (fifo_full) begin
               tcnt_nxt = '0;
            end else if (tcnt == TLIM) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               terr_nxt  = 1'b1;
               tid_nxt   = last_id;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         last_id     <= 3'(NREQ - 1);
         tcnt        <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= 3'd0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         last_id     <= last_id_nxt;
         tcnt        <= tcnt_nxt;
         timeout_err <= terr_nxt;
         timeout_id  <= tid_nxt;
      end
   end

endmodule
